// File: rtl/cpu_branch_resolver.sv
// Branch/jump resolver: registers one control-transfer op, evaluates it, and
// reports direction/next PC, flushing and redirecting fetch on a mispredict.

module cpu_branch_tester #(
   parameter int unsigned XLEN = 32
) (
   input  logic [2:0]      funct3,
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   output logic            cond_c
);
   // Unmapped condition codes never take the branch
   always_comb begin
      cond_c = 1'b0;
      case (funct3)
         3'b000:  cond_c = (a == b);
         3'b001:  cond_c = (a != b);
         3'b100:  cond_c = ($signed(a) <  $signed(b));
         3'b101:  cond_c = ($signed(a) >= $signed(b));
         3'b110:  cond_c = (a <  b);
         3'b111:  cond_c = (a >= b);
         default: cond_c = 1'b0;
      endcase
   end
endmodule

module cpu_branch_resolver #(
   parameter int unsigned XLEN        = 32,
   parameter int unsigned CNT_W       = 16,
   parameter bit          ALIGN_CHECK = 1'b1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [2:0]       funct3,
   input  logic             is_jal,
   input  logic             is_jalr,
   input  logic [XLEN-1:0]  operand_a,
   input  logic [XLEN-1:0]  operand_b,
   input  logic [XLEN-1:0]  pc,
   input  logic [XLEN-1:0]  imm,
   input  logic             predicted_taken,
   output logic             done,
   output logic             taken,
   output logic [XLEN-1:0]  next_pc,
   output logic             flush,
   output logic             redirect_valid,
   output logic [XLEN-1:0]  redirect_pc,
   input  logic             redirect_ack,
   output logic             misalign,
   output logic [CNT_W-1:0] mispredict_count
);
   typedef enum logic [1:0] {IDLE, EVAL, REDIRECT} state_t;

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   state_t            state, state_nx;
   logic [2:0]        funct3_q;
   logic              jal_q, jalr_q, pred_q;
   logic [XLEN-1:0]   a_q, b_q, pc_q, imm_q;

   logic              capture;
   logic              cond_c;
   logic              br_taken;
   logic              misal;
   logic [XLEN-1:0]   sum_a, sum_pc, target, res_pc;

   logic              done_nx, taken_nx, flush_nx, misalign_nx, redirect_valid_nx, req_ready_nx;
   logic [XLEN-1:0]   next_pc_nx, redirect_pc_nx;
   logic [CNT_W-1:0]  cnt_nx;

   cpu_branch_tester #(.XLEN(XLEN)) u_tester (
      .funct3 (funct3_q),
      .a      (a_q),
      .b      (b_q),
      .cond_c (cond_c)
   );

   // Resolution datapath on the registered operands; jalr wins over jal
   always_comb begin
      sum_a    = a_q + imm_q;
      sum_pc   = pc_q + imm_q;
      target   = jalr_q ? (sum_a & ~XLEN'(1)) : sum_pc;
      br_taken = jal_q | jalr_q | cond_c;
      res_pc   = br_taken ? target : (pc_q + XLEN'(4));
      misal    = ALIGN_CHECK && br_taken && (target[1:0] != 2'b00);
   end

   always_comb begin
      state_nx          = state;
      capture           = 1'b0;
      done_nx           = 1'b0;
      flush_nx          = 1'b0;
      misalign_nx       = 1'b0;
      taken_nx          = taken;
      next_pc_nx        = next_pc;
      redirect_valid_nx = redirect_valid;
      redirect_pc_nx    = redirect_pc;
      cnt_nx            = mispredict_count;
      case (state)
         IDLE: begin
            if (req_valid && req_ready) begin
               capture  = 1'b1;
               state_nx = EVAL;
            end
         end
         EVAL: begin
            taken_nx   = br_taken;
            next_pc_nx = res_pc;
            if (misal) begin
               misalign_nx = 1'b1;
               done_nx     = 1'b1;
               state_nx    = IDLE;
            end else if (br_taken == pred_q) begin
               done_nx  = 1'b1;
               state_nx = IDLE;
            end else begin
               flush_nx          = 1'b1;
               cnt_nx            = (mispredict_count == CNT_MAX) ? mispredict_count
                                                                 : mispredict_count + CNT_W'(1);
               redirect_pc_nx    = res_pc;
               redirect_valid_nx = 1'b1;
               state_nx          = REDIRECT;
            end
         end
         REDIRECT: begin
            if (redirect_ack) begin
               done_nx           = 1'b1;
               redirect_valid_nx = 1'b0;
               state_nx          = IDLE;
            end
         end
         default: state_nx = IDLE;
      endcase
      // Hold off acceptance during the retire pulse so done and accept never coincide
      req_ready_nx = (state_nx == IDLE) && !done_nx;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state            <= IDLE;
         req_ready        <= 1'b1;
         done             <= 1'b0;
         taken            <= 1'b0;
         next_pc          <= '0;
         flush            <= 1'b0;
         misalign         <= 1'b0;
         redirect_valid   <= 1'b0;
         redirect_pc      <= '0;
         mispredict_count <= '0;
         funct3_q         <= '0;
         jal_q            <= 1'b0;
         jalr_q           <= 1'b0;
         pred_q           <= 1'b0;
         a_q              <= '0;
         b_q              <= '0;
         pc_q             <= '0;
         imm_q            <= '0;
      end else begin
         state            <= state_nx;
         req_ready        <= req_ready_nx;
         done             <= done_nx;
         taken            <= taken_nx;
         next_pc          <= next_pc_nx;
         flush            <= flush_nx;
         misalign         <= misalign_nx;
         redirect_valid   <= redirect_valid_nx;
         redirect_pc      <= redirect_pc_nx;
         mispredict_count <= cnt_nx;
         if (capture) begin
            funct3_q <= funct3;
            jal_q    <= is_jal;
            jalr_q   <= is_jalr;
            pred_q   <= predicted_taken;
            a_q      <= operand_a;
            b_q      <= operand_b;
            pc_q     <= pc;
            imm_q    <= imm;
         end
      end
   end
endmodule
